// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control inputs and status outputs of the phase sequencer.
// The master side drives halt/step controls; the slave side is the sequencer.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 8,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    logic                  halt;
    logic                  step_mode;
    logic                  step;
    logic [NUM_PHASES-1:0] state;
    logic [IDX_W-1:0]      phase_idx;
    logic                  fetch;
    logic                  alu_en;
    logic                  cycle_done;
    logic [CNT_W-1:0]      instr_count;

    modport master (
        output halt, step_mode, step,
        input  state, phase_idx, fetch, alu_en, cycle_done, instr_count
    );

    modport slave (
        input  halt, step_mode, step,
        output state, phase_idx, fetch, alu_en, cycle_done, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot instruction-cycle phase generator. Produces registered
// fetch/ALU enable windows, a start-of-cycle pulse and a completed-cycle counter,
// with halt, single-step gating of the wrap, and recovery from corrupted state.
module phase_sequencer #(
    parameter int NUM_PHASES   = 8,
    parameter int FETCH_SET_PH = 7,
    parameter int FETCH_CLR_PH = 3,
    parameter int ALU_SET_PH   = 5,
    parameter int ALU_CLR_PH   = 6,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    phase_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PHASES);
    localparam int LAST  = NUM_PHASES - 1;

    if (NUM_PHASES < 4 || NUM_PHASES > 16 ||
        FETCH_SET_PH < 0 || FETCH_SET_PH >= NUM_PHASES ||
        FETCH_CLR_PH < 0 || FETCH_CLR_PH >= NUM_PHASES ||
        ALU_SET_PH   < 0 || ALU_SET_PH   >= NUM_PHASES ||
        ALU_CLR_PH   < 0 || ALU_CLR_PH   >= NUM_PHASES ||
        FETCH_SET_PH == FETCH_CLR_PH || ALU_SET_PH == ALU_CLR_PH) begin : g_param_check
        $error("phase_sequencer: illegal parameter combination");
    end

    // Kind of transition the next edge performs.
    typedef enum logic [2:0] {
        MV_HOLD,
        MV_START,
        MV_ADVANCE,
        MV_WRAP,
        MV_RECOVER
    } move_e;

    move_e                 move;
    logic                  leaving;
    logic [NUM_PHASES-1:0] state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  fetch_q, fetch_d;
    logic                  alu_q, alu_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Classify the upcoming edge: halt beats everything, step mode only gates the wrap.
    always_comb begin
        move = MV_HOLD;
        if (bus.halt) begin
            move = MV_HOLD;
        end else if (state_q == '0) begin
            move = MV_START;
        end else if (!$onehot(state_q)) begin
            move = MV_RECOVER;
        end else if (state_q[LAST]) begin
            move = (bus.step_mode && !bus.step) ? MV_HOLD : MV_WRAP;
        end else begin
            move = MV_ADVANCE;
        end
    end

    // Next-state values; window set/clear decoded from the phase being left.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        done_d  = 1'b0;
        leaving = (move == MV_ADVANCE) || (move == MV_WRAP);

        fetch_d = fetch_q;
        if (leaving && state_q[FETCH_SET_PH]) fetch_d = 1'b1;
        if (leaving && state_q[FETCH_CLR_PH]) fetch_d = 1'b0;

        alu_d = alu_q;
        if (leaving && state_q[ALU_SET_PH]) alu_d = 1'b1;
        if (leaving && state_q[ALU_CLR_PH]) alu_d = 1'b0;

        case (move)
            MV_START: begin
                state_d = NUM_PHASES'(1);
                idx_d   = '0;
            end
            MV_ADVANCE: begin
                state_d = state_q << 1;
                idx_d   = idx_q + IDX_W'(1);
            end
            MV_WRAP: begin
                state_d = NUM_PHASES'(1);
                idx_d   = '0;
                count_d = count_q + CNT_W'(1);
                done_d  = 1'b1;
            end
            MV_RECOVER: begin
                state_d = '0;
                idx_d   = '0;
            end
            default: ;
        endcase
    end

    // All sequencer state, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            idx_q   <= '0;
            fetch_q <= 1'b0;
            alu_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fetch_q <= fetch_d;
            alu_q   <= alu_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.phase_idx   = idx_q;
    assign bus.fetch       = fetch_q;
    assign bus.alu_en      = alu_q;
    assign bus.cycle_done  = done_q;
    assign bus.instr_count = count_q;
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_PHASES, default 8: number of one-hot phases per instruction cycle; legal range 4..16.
REQ-002 Parameter FETCH_SET_PH, default 7: index of the phase whose exit edge sets fetch.
REQ-003 Parameter FETCH_CLR_PH, default 3: index of the phase whose exit edge clears fetch.
REQ-004 Parameter ALU_SET_PH, default 5: index of the phase whose exit edge sets alu_en.
REQ-005 Parameter ALU_CLR_PH, default 6: index of the phase whose exit edge clears alu_en.
REQ-006 Parameter CNT_W, default 16: width of the instruction-cycle counter.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 halt  input  1  stall request; freezes all state while high.
REQ-010 step_mode  input  1  single-step enable; the wrap from the last phase waits for step.
REQ-011 step  input  1  single-step advance strobe; sampled only when step_mode=1.
REQ-012 state  output  NUM_PHASES  one-hot phase vector, bit i = phase i; all-zero = IDLE.
REQ-013 phase_idx  output  clog2(NUM_PHASES)  binary index of the current phase; 0 in IDLE.
REQ-014 fetch  output  1  registered fetch window.
REQ-015 alu_en  output  1  registered ALU-enable window.
REQ-016 cycle_done  output  1  one-clock pulse marking the start of a new instruction cycle.
REQ-017 instr_count  output  CNT_W  number of completed instruction cycles, modulo 2^CNT_W.

Function
REQ-018 Elaboration shall fail if NUM_PHASES lies outside 4..16, any *_PH index is >= NUM_PHASES, FETCH_SET_PH equals FETCH_CLR_PH, or ALU_SET_PH equals ALU_CLR_PH.
REQ-019 Priority per edge: rst, then halt, then step-mode gating, then normal advance.
REQ-020 halt=1: state, phase_idx, fetch, alu_en, instr_count hold; cycle_done = 0.
REQ-021 Transitions: IDLE -> phase 0; phase i -> phase i+1 for i < NUM_PHASES-1; phase NUM_PHASES-1 -> phase 0 (wrap).
REQ-022 step_mode=1 and state = phase NUM_PHASES-1: the wrap occurs only on an edge with step=1; otherwise state holds and fetch/alu_en hold.
REQ-023 step_mode shall not gate any transition other than the wrap; step is ignored when step_mode=0.
REQ-024 Any non-one-hot, non-zero state shall go to IDLE on the next edge, with fetch and alu_en holding.
REQ-025 fetch shall go to 1 on every edge that leaves phase FETCH_SET_PH and to 0 on every edge that leaves phase FETCH_CLR_PH; at all other times it holds.
REQ-026 alu_en shall follow the same rule as fetch, using ALU_SET_PH and ALU_CLR_PH, and shall be independent of fetch.
REQ-027 The fetch and alu_en updates shall be computed in parallel, so that one edge may update both.
REQ-028 An edge that does not leave the current phase (halt, or a step-mode wait) shall not set or clear fetch or alu_en.
REQ-029 instr_count shall increment by 1 on every wrap edge and wrap from 2^CNT_W-1 to 0; IDLE -> phase 0 shall not count.
REQ-030 cycle_done shall be registered and high for exactly the first clock of phase 0 after a wrap; it shall be 0 after IDLE -> phase 0.
REQ-031 phase_idx shall be registered and consistent with state in the same cycle.

Reset
REQ-032 rst=1: immediately, without waiting for clk, state=0 (IDLE), phase_idx=0, fetch=0, alu_en=0, cycle_done=0, instr_count=0.
REQ-033 Reset asserted mid-cycle shall abort the cycle without incrementing instr_count.
REQ-034 First rising edge after rst deasserts, with halt=0: state = phase 0.

Verification
REQ-035 Defaults, halt=0, step_mode=0, 20 edges after reset: state = 0x01, 0x02, ..., 0x80, 0x01, ...; fetch=0 through the first pass, then 1 in phases 0-3 and 0 in phases 4-7; alu_en=1 in phase 6 only; cycle_done high at edge 9 and edge 17.
REQ-036 halt=1 for 3 clocks while in phase 2 with fetch=1 -> state=0x04, fetch=1, instr_count unchanged for those 3 clocks; on release, advance to 0x08.
REQ-037 step_mode=1, step=0, reaching phase 7 -> state stays 0x80 for 5 clocks; step=1 for one clock -> state=0x01, cycle_done=1, instr_count+1, fetch=1.
REQ-038 CNT_W=4, 16 wraps -> instr_count goes 15 -> 0.
REQ-039 Force state=0x24 -> IDLE on next edge, phase 0 on the edge after; rst asserted in phase 5 -> all outputs 0 asynchronously.
REQ-040 NUM_PHASES=12, FETCH_SET_PH=11, FETCH_CLR_PH=5, ALU_SET_PH=8, ALU_CLR_PH=9 -> 12-phase period; fetch high in phases 0-5, alu_en high in phase 9.
